// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
// Segment patterns are active-low: bit7=dp, bits6:0 = g..a.
package seg_pkg;

    localparam int unsigned SEG_W  = 8;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned SEG_DP = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

    // Entry n is the glyph for hex value n (index 0 in the low byte).
    localparam logic [15:0][SEG_W-1:0] GLYPH = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/hex7_decode.sv
// Combinational hex nibble to active-low 7-segment pattern with decimal point.
module hex7_decode
    import seg_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    input  logic             dp,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = GLYPH[nibble];
        if (dp) begin
            seg_c[SEG_DP] = 1'b0;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with per-slot
// dead-time, frame-coherent input snapshot and frame-based blinking.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 8,
    parameter int unsigned SCAN_DIV      = 100000,
    parameter int unsigned GUARD_CYCLES  = 2000,
    parameter int unsigned BLINK_FRAMES  = 64,
    parameter bit          AN_ACTIVE_LOW = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [NIB_W*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]       dp_en,
    input  logic [NUM_DIGITS-1:0]       blank_mask,
    input  logic [NUM_DIGITS-1:0]       blink_mask,
    output logic [SEG_W-1:0]            seg_out,
    output logic [NUM_DIGITS-1:0]       an_out,
    output logic                        frame_start
);

    localparam int unsigned PRE_W = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
    localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [PRE_W-1:0] GUARD    = PRE_W'(GUARD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                             : {NUM_DIGITS{1'b0}};

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [FRM_W-1:0] frm_q, frm_d;
    logic             blink_q, blink_d;

    logic [NUM_DIGITS-1:0][NIB_W-1:0] dig_q, dig_d;
    logic [NUM_DIGITS-1:0]            dp_q, dp_d;
    logic [NUM_DIGITS-1:0]            blank_q, blank_d;
    logic [NUM_DIGITS-1:0]            blinkm_q, blinkm_d;

    logic [SEG_W-1:0]      seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  fs_q, fs_d;

    logic             snap_c;
    logic             dark_c;
    logic [SEG_W-1:0] glyph_c;

    hex7_decode u_hex7 (
        .nibble (dig_q[idx_q]),
        .dp     (dp_q[idx_q]),
        .seg_c  (glyph_c)
    );

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q    <= '0;
            idx_q    <= '0;
            frm_q    <= '0;
            blink_q  <= 1'b0;
            dig_q    <= '0;
            dp_q     <= '0;
            blank_q  <= '0;
            blinkm_q <= '0;
            seg_q    <= SEG_BLANK;
            an_q     <= AN_OFF;
            fs_q     <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            idx_q    <= idx_d;
            frm_q    <= frm_d;
            blink_q  <= blink_d;
            dig_q    <= dig_d;
            dp_q     <= dp_d;
            blank_q  <= blank_d;
            blinkm_q <= blinkm_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            fs_q     <= fs_d;
        end
    end

    // Scan counters, snapshot capture and blink phase
    always_comb begin
        pre_d    = pre_q;
        idx_d    = idx_q;
        frm_d    = frm_q;
        blink_d  = blink_q;
        dig_d    = dig_q;
        dp_d     = dp_q;
        blank_d  = blank_q;
        blinkm_d = blinkm_q;
        snap_c   = enable && (pre_q == '0) && (idx_q == '0);

        if (!enable) begin
            pre_d   = '0;
            idx_d   = '0;
            frm_d   = '0;
            blink_d = 1'b0;
        end else begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end

            if (snap_c) begin
                dig_d    = digits;
                dp_d     = dp_en;
                blank_d  = blank_mask;
                blinkm_d = blink_mask;
                if (frm_q == FRM_LAST) begin
                    frm_d   = '0;
                    blink_d = ~blink_q;
                end else begin
                    frm_d = frm_q + FRM_W'(1);
                end
            end
        end
    end

    // Output stage: guard window keeps every anode off while segments settle
    always_comb begin
        seg_d  = SEG_BLANK;
        an_d   = AN_OFF;
        fs_d   = snap_c;
        dark_c = blank_q[idx_q] | (blinkm_q[idx_q] & blink_q);

        if (enable && (pre_q >= GUARD)) begin
            an_d = AN_OFF ^ (NUM_DIGITS'(1) << idx_q);
            if (!dark_c) begin
                seg_d = glyph_c;
            end
        end
    end

    assign seg_out     = seg_q;
    assign an_out      = an_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed scoreboard bench for seg_scan_driver (4 digits, 8-cycle slots).
module tb_seg_scan_driver;

    localparam int ND    = 4;
    localparam int DIV   = 8;
    localparam int GRD   = 2;
    localparam int BF    = 2;
    localparam int FRAME = ND * DIV;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
        logic       fs;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic [15:0]   digits;
    logic [3:0]    dp_en;
    logic [3:0]    blank_mask;
    logic [3:0]    blink_mask;
    logic [7:0]    seg_out;
    logic [3:0]    an_out;
    logic          frame_start;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    // Values the bench believes the DUT captured at the last frame boundary
    logic [15:0] cur_dig;
    logic [3:0]  cur_dp, cur_blank, cur_blink;

    logic [7:0] glyph_tb [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seg_scan_driver #(
        .NUM_DIGITS    (ND),
        .SCAN_DIV      (DIV),
        .GUARD_CYCLES  (GRD),
        .BLINK_FRAMES  (BF),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .digits      (digits),
        .dp_en       (dp_en),
        .blank_mask  (blank_mask),
        .blink_mask  (blink_mask),
        .seg_out     (seg_out),
        .an_out      (an_out),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check3(input string tag, input int step, input exp_t e);
        checks++;
        assert (an_out === e.an) else begin
            failures++;
            $error("FAIL %s[%0d] an_out got %b expected %b", tag, step, an_out, e.an);
        end
        checks++;
        assert (seg_out === e.seg) else begin
            failures++;
            $error("FAIL %s[%0d] seg_out got %h expected %h", tag, step, seg_out, e.seg);
        end
        checks++;
        assert (frame_start === e.fs) else begin
            failures++;
            $error("FAIL %s[%0d] frame_start got %b expected %b", tag, step, frame_start, e.fs);
        end
        checks++;
        assert ($countones(~an_out) <= 1) else begin
            failures++;
            $error("FAIL %s[%0d] onehot an_out got %b expected at most one 0", tag, step, an_out);
        end
    endtask

    task automatic push_dark(input int n);
        exp_t e;
        e.an  = 4'hF;
        e.seg = 8'hFF;
        e.fs  = 1'b0;
        for (int j = 0; j < n; j++) exp_q.push_back(e);
    endtask

    // Expected outputs for positions k0..k1 of frame n (frames counted since scanning began)
    task automatic push_frame(input int n, input int k0, input int k1);
        exp_t e;
        int   p, d;
        bit   phase;
        logic [3:0] nib;
        phase = (((n + 1) / BF) % 2) == 1;
        for (int k = k0; k <= k1; k++) begin
            p     = k % DIV;
            d     = k / DIV;
            e.fs  = (k == 0);
            e.an  = 4'hF;
            e.seg = 8'hFF;
            if (p >= GRD) begin
                e.an = 4'hF & ~(4'b0001 << d);
                if (!(cur_blank[d] || (cur_blink[d] && phase))) begin
                    nib   = cur_dig[4*d +: 4];
                    e.seg = glyph_tb[nib];
                    if (cur_dp[d]) e.seg[7] = 1'b0;
                end
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic run(input int n, input string tag);
        exp_t e;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL %s[%0d] scoreboard got empty expected entry", tag, j);
            end else begin
                e = exp_q.pop_front();
                check3(tag, j, e);
            end
        end
    endtask

    task automatic latch_cur();
        cur_dig   = digits;
        cur_dp    = dp_en;
        cur_blank = blank_mask;
        cur_blink = blink_mask;
    endtask

    initial begin
        exp_t dark_e;
        dark_e = '{an: 4'hF, seg: 8'hFF, fs: 1'b0};

        rst_n      = 1'b1;
        enable     = 1'b0;
        digits     = 16'h0000;
        dp_en      = 4'h0;
        blank_mask = 4'h0;
        blink_mask = 4'h0;
        #1 rst_n = 1'b0;

        push_dark(3);
        run(3, "reset");
        rst_n = 1'b1;
        push_dark(3);
        run(3, "idle");

        // Normal scanning of 1234
        digits = 16'h1234;
        enable = 1'b1;
        latch_cur();
        push_frame(0, 0, FRAME - 1);
        run(FRAME, "f1234");

        dp_en = 4'b0100;
        latch_cur();
        push_frame(1, 0, FRAME - 1);
        run(FRAME, "dp");

        // Mid-frame digit change must not show until the next frame
        dp_en = 4'b0000;
        latch_cur();
        push_frame(2, 0, FRAME - 1);
        run(9, "mid");
        digits = 16'hABCD;
        run(FRAME - 9, "mid");
        latch_cur();
        push_frame(3, 0, FRAME - 1);
        run(FRAME, "abcd");

        // Blank digit 3, blink digit 0
        digits     = 16'h1234;
        blink_mask = 4'b0001;
        blank_mask = 4'b1000;
        latch_cur();
        for (int n = 4; n < 10; n++) begin
            push_frame(n, 0, FRAME - 1);
            run(FRAME, "blink");
        end

        // Disable mid-slot, then resume from digit 0 with guard and fresh blink phase
        push_frame(10, 0, 12);
        run(13, "pre_dis");
        enable = 1'b0;
        push_dark(5);
        run(5, "dis");
        enable = 1'b1;
        push_frame(0, 0, FRAME - 1);
        run(FRAME, "re0");
        push_frame(1, 0, FRAME - 1);
        run(FRAME, "re1");

        // Asynchronous reset while a digit is lit
        blank_mask = 4'b0000;
        blink_mask = 4'b0000;
        latch_cur();
        push_frame(2, 0, 12);
        run(13, "pre_rst");
        #2 rst_n = 1'b0;
        #1 check3("async_rst", 0, dark_e);
        push_dark(2);
        run(2, "rst_hold");
        rst_n = 1'b1;
        push_frame(0, 0, FRAME - 1);
        run(FRAME, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
